// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, oversampling ratio and default baud setup.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE       = 16;
    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_BAUD         = 19200;
    localparam int DEF_DBIT         = 8;
    localparam int DEF_SB_TICK      = 16;
    // Rounded to nearest: 50 MHz / (19200 * 16) = 162.76 -> 163
    localparam int DEF_CLK_PER_TICK = (DEF_CLK_HZ + (DEF_BAUD * OVERSAMPLE) / 2) / (DEF_BAUD * OVERSAMPLE);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } tx_state_t;
`endif

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/status bundle between a byte producer (master) and the UART transmitter (slave).
interface uart_tx_frame_if #(
    parameter int DBIT = 8
);
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            tx;
    logic            tx_busy;
    logic            tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every CLK_PER_TICK clocks, held at zero by clear.
// Shared between the UART transmitter and receiver so both use the same tick phase convention.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_PER_TICK = DEF_CLK_PER_TICK
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            TW   = cnt_width(CLK_PER_TICK);
    localparam logic [TW-1:0] LAST = TW'(CLK_PER_TICK - 1);

    logic [TW-1:0] cnt_reg;
    logic [TW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (cnt_reg == LAST) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Suppressed while cleared so the first tick lands a full period after release.
    assign tick = !clear && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DBIT         = DEF_DBIT,
    parameter int SB_TICK      = DEF_SB_TICK,
    parameter int CLK_PER_TICK = DEF_CLK_PER_TICK
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_frame_if.slave bus
);

    localparam int            NW          = cnt_width(DBIT);
    localparam logic [4:0]    S_BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    tx_state_t       state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            tx_reg, tx_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
`ifdef UART_TX_PARITY_EN
    logic            parity_reg, parity_next;
`endif

    logic tick;
    logic tick_clear;

    // The tick counter restarts on every frame so bit boundaries align with the accept edge.
    assign tick_clear = (state_reg == IDLE);

    uart_baud_tick #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_baud_tick (
        .clock(clock),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shift_next = shift_reg;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.tx_start) begin
                    shift_next = bus.tx_data;
                    s_next     = '0;
                    n_next     = '0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^bus.tx_data;
`endif
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        shift_next = shift_reg >> 1;
                        if (n_reg == N_LAST) begin
                            n_next = '0;
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_reg == S_STOP_LAST) begin
                        s_next     = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so tx itself comes straight from a flop.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            n_reg      <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            n_reg      <= n_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign bus.tx      = tx_reg;
    assign bus.tx_busy = busy_reg;
    assign bus.tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame with CLK_PER_TICK=2 (32 clocks per bit) and SB_TICK=16.
module tb_uart_tx_frame;

    localparam int CPT = 2;
    localparam int SBT = 16;
    localparam int BC  = 16 * CPT;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int FLEN = (NB - 1) * BC + SBT * CPT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame_if #(.DBIT(8)) bus ();

    uart_tx_frame #(
        .DBIT(8),
        .SB_TICK(SBT),
        .CLK_PER_TICK(CPT)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] bits;   // bit i = i-th level on the line (start first)
        int          len;    // clocks from accept edge to tx_done
        int          mid_k;  // cycle of a mid-frame request, -1 for none
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(name, {29'b0, bus.tx, bus.tx_busy, bus.tx_done}, 32'b100);
        end
    endtask

    // Reference frame computed from the line protocol: start, data LSB-first, parity by counting ones, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = d[i];
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        f[9]  = ((ones % 2) == 1);
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the first negedge after the accept edge; returns at the tx_done cycle.
    task automatic watch_frame(input logic [10:0] bits, input int len, input int mid_k, input bit hold);
        int       nbad;
        int       idx;
        logic [2:0] exp3;
        logic [2:0] first_got;
        nbad      = 0;
        first_got = '0;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            if (k < len) begin
                idx  = k / BC;
                if (idx > NB - 1) idx = NB - 1;
                exp3 = {bits[idx], 1'b1, 1'b0};
                if ({bus.tx, bus.tx_busy, bus.tx_done} !== exp3) begin
                    if (nbad == 0) first_got = {bus.tx, bus.tx_busy, bus.tx_done};
                    nbad++;
                end
                if (((k % BC) == BC - 1) || (k == len - 1)) begin
                    total++;
                    if (nbad != 0) begin
                        bad++;
                        $display("FAIL frame_bit%0d tx/busy/done=%b required=%b (%0d bad cycles)",
                                 idx, first_got, exp3, nbad);
                    end
                    nbad = 0;
                end
            end else begin
                chk("done_cycle", {29'b0, bus.tx, bus.tx_busy, bus.tx_done}, 32'b101);
            end
            if (k == 0 && !hold) bus.tx_start = 1'b0;
            if (mid_k >= 0 && k == mid_k) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h00;
            end
            if (mid_k >= 0 && k == mid_k + 1) bus.tx_start = 1'b0;
        end
    endtask

    initial begin
        logic [7:0]  d;
        logic [10:0] f;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{data: 8'h07, bits: 11'h60E, len: 352, mid_k: -1};
        vecs[1] = '{data: 8'h03, bits: 11'h406, len: 352, mid_k: -1};
        vecs[2] = '{data: 8'hA3, bits: 11'h546, len: 352, mid_k: 100};
`else
        vecs[0] = '{data: 8'h55, bits: 11'h2AA, len: 320, mid_k: -1};
        vecs[1] = '{data: 8'hA3, bits: 11'h346, len: 320, mid_k: 100};
        vecs[2] = '{data: 8'h07, bits: 11'h20E, len: 320, mid_k: -1};
`endif

        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset held, then a long idle stretch.
        repeat (5) @(negedge clk);
        chk("in_reset", {29'b0, bus.tx, bus.tx_busy, bus.tx_done}, 32'b100);
        rst_n = 1'b1;
        idle_cycles(100, "idle_after_reset");

        // Table vectors, one frame each, then a quiet line with no queued frame.
        for (int v = 0; v < 3; v++) begin
            $display("frame data=%02h mid_request=%0d", vecs[v].data, vecs[v].mid_k);
            send(vecs[v].data);
            watch_frame(vecs[v].bits, vecs[v].len, vecs[v].mid_k, 1'b0);
            idle_cycles(40, "no_second_frame");
        end

        // tx_start held high: frames must follow with a single idle clock between them.
        $display("frame data=ff held start, 3 frames");
        f = model_frame(8'hFF);
        send(8'hFF);
        for (int fr = 0; fr < 3; fr++) begin
            if (fr > 0) @(negedge clk);
            watch_frame(f, FLEN, -1, 1'b1);
        end
        bus.tx_start = 1'b0;
        idle_cycles(10, "idle_after_hold");

        // Reset during data bit 3 of an all-zero byte, then a clean frame.
        $display("frame data=00 reset mid-frame");
        send(8'h00);
        repeat (140) @(negedge clk);
        chk("pre_reset_bit3", {31'b0, bus.tx}, 32'b0);
        bus.tx_start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {29'b0, bus.tx, bus.tx_busy, bus.tx_done}, 32'b100);
        idle_cycles(3, "held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(5, "after_reset_release");
        $display("frame data=0f after reset");
        send(8'h0F);
        watch_frame(model_frame(8'h0F), FLEN, -1, 1'b0);
        idle_cycles(5, "idle_after_0f");

        // Random bytes with random idle gaps against the reference model.
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom_range(0, 255));
            $display("frame data=%02h random", d);
            send(d);
            watch_frame(model_frame(d), FLEN, -1, 1'b0);
            idle_cycles(1 + int'($urandom_range(0, 3)), "random_gap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter. Serialises one byte per request onto `tx` as start bit, 8 data bits LSB-first, optional parity, then stop bit.
- Pairs with the existing UART receiver in the UART Top. Drives the `tx` pin, which the receiver side of a link samples with 16x oversampling.
- Contains its own oversampling tick generator, so bit timing matches the receiver's tick convention exactly.

Parameters:
- DBIT, 8, number of data bits per frame.
- SB_TICK, 16, stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- CLK_PER_TICK, 163, clock cycles per oversampling tick (50 MHz / 19200 baud / 16). Must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  request to send; sampled every clock.
- tx_data  in  DBIT  byte to send; captured on the accepting cycle.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (reset=0, async): tx=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters=0, shift register=0.
- States: IDLE, START, DATA, [PARITY], STOP.
- Tick generator: counter 0..CLK_PER_TICK-1. It produces a one-cycle `tick` when it wraps. It is held at 0 in IDLE and released on the cycle after acceptance, so every bit is exactly 16*CLK_PER_TICK clocks long.
- IDLE: tx=1, tx_busy=0. When tx_start=1:
  - latch tx_data into the shift register;
  - clear the tick count s and the bit count n;
  - go to START.
- Acceptance latency: tx goes low and tx_busy goes high on the clock edge that samples tx_start=1, i.e. both are visible the cycle after the request.
- START: tx=0 for 16 ticks. On the 16th tick (s=15 and tick) set s=0 and go to DATA.
- DATA: tx = shift register bit 0.
  - Each bit lasts 16 ticks.
  - At the end of a bit, shift right and increment n.
  - After bit DBIT-1: go to PARITY if enabled, otherwise STOP.
- STOP: tx=1 for SB_TICK ticks. At the end, go to IDLE and assert tx_done for exactly that one cycle; tx_busy drops in the same cycle.
- tx_start while busy: ignored. No queueing; tx_data changes have no effect mid-frame.
- Back-to-back frames: tx_start held high during the tx_done cycle is sampled in IDLE on the next cycle. The minimum inter-frame gap is therefore 1 clock of idle-high after the stop bit.
- Reset mid-frame: immediate return to the reset values above. tx returns high asynchronously, and no tx_done is produced.
- Width rules:
  - s is 5 bits, wide enough to count to 31 (SB_TICK=32).
  - n is ceil(log2(DBIT)) bits.
  - The tick counter is ceil(log2(CLK_PER_TICK)) bits, minimum 1.
  - All counters wrap only under FSM control, never freely.
- All outputs are registered; tx is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state follows DATA. tx = even parity (XOR of the latched data) for 16 ticks, then STOP. Frame length grows by 16*CLK_PER_TICK clocks.
- Not defined: no PARITY state exists in the FSM encoding, and DATA goes straight to STOP.

Decomposition:
- Package uart_pkg holds:
  - state typedef tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - constant OVERSAMPLE=16;
  - default baud constants shared with the receiver.
- One sub-module, uart_baud_tick, contains the tick counter with inputs clock, reset and clear, and output tick. The receiver can reuse it.

Test Plan (CLK_PER_TICK=2, so 1 bit = 32 clocks; SB_TICK=16):
- Reset held, then released with tx_start=0 for 100 clocks -> tx=1, tx_busy=0, tx_done=0 throughout.
- Pulse tx_start one cycle with tx_data=8'h55. Expected tx sequence, each level for 32 clocks: 0,1,0,1,0,1,0,1,0,1. tx_done pulses exactly 320 clocks after the accept edge and tx_busy falls in that same cycle.
- Send 8'hA3, then assert tx_start with 8'h00 at clock 100 mid-frame -> the frame still carries 1,1,0,0,0,1,0,1 and no second frame follows.
- Hold tx_start=1 continuously with 8'hFF -> consecutive frames, each starting exactly 1 clock after the previous tx_done.
- Drive reset=0 during DATA bit 3 -> tx=1 and tx_busy=0 asynchronously, no tx_done. After release, a new 8'h0F frame is correct.
- UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 for 32 clocks after bit 7, and tx_done at 352 clocks. With 8'h03 the parity bit is 0.
